// File: rtl/spi_slave_frame_ctrl_if.sv
// SPI pins and RAM-side handshake of the SPI slave frame controller.
// The slave modport is the controller; the master modport is the SPI host / RAM side.
interface spi_slave_frame_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              MISO;
  logic              rx_valid;
  logic [DATA_W+1:0] rx_data;
  logic              addr_pending;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  SS_n, MOSI, tx_valid, tx_data,
    output MISO, rx_valid, rx_data, addr_pending, frame_err, busy
  );

  modport master (
    output SS_n, MOSI, tx_valid, tx_data,
    input  MISO, rx_valid, rx_data, addr_pending, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_frame_ctrl.sv
// SPI slave frame controller: deserialises {cmd, payload} frames from MOSI and,
// after a read-data frame, serialises RAM read data onto MISO with a bounded wait.
module spi_slave_frame_ctrl #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned LSB_FIRST   = 0,
  parameter int unsigned TX_WAIT_MAX = 16
) (
  input logic                    clk,
  input logic                    rst,
  spi_slave_frame_ctrl_if.slave  bus
);

  localparam int unsigned FRAME_W = DATA_W + 2;
  localparam int unsigned BCNT_W  = $clog2(FRAME_W + 1);
  localparam int unsigned WCNT_W  = $clog2(TX_WAIT_MAX + 1);
  localparam int unsigned TCNT_W  = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    TX_WAIT,
    TX_SHIFT
  } state_t;

  state_t               state, state_n;
  logic [BCNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [FRAME_W-1:0]   shift_reg, shift_n;
  logic [WCNT_W-1:0]    wait_cnt, wait_cnt_n;
  logic [DATA_W-1:0]    tx_sh, tx_sh_n;
  logic [TCNT_W-1:0]    tx_cnt, tx_cnt_n;
  logic                 miso, miso_n;
  logic                 rx_valid, rx_valid_n;
  logic [FRAME_W-1:0]   rx_data, rx_data_n;
  logic                 addr_pend, addr_pend_n;
  logic                 frame_err, frame_err_n;
  logic                 busy, busy_n;

  logic [FRAME_W-1:0]   frame_c;
  logic [1:0]           cmd_c;
  logic                 legal_c;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      wait_cnt  <= '0;
      tx_sh     <= '0;
      tx_cnt    <= '0;
      miso      <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      addr_pend <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_n;
      wait_cnt  <= wait_cnt_n;
      tx_sh     <= tx_sh_n;
      tx_cnt    <= tx_cnt_n;
      miso      <= miso_n;
      rx_valid  <= rx_valid_n;
      rx_data   <= rx_data_n;
      addr_pend <= addr_pend_n;
      frame_err <= frame_err_n;
      busy      <= busy_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift_reg;
    wait_cnt_n  = wait_cnt;
    tx_sh_n     = tx_sh;
    tx_cnt_n    = tx_cnt;
    miso_n      = 1'b0;
    rx_valid_n  = 1'b0;
    rx_data_n   = rx_data;
    addr_pend_n = addr_pend;
    frame_err_n = 1'b0;

    frame_c = {shift_reg[FRAME_W-2:0], bus.MOSI};
    cmd_c   = frame_c[FRAME_W-1 -: 2];
    legal_c = ((state == WRITE)     && !cmd_c[1])       ||
              ((state == READ_ADD)  && (cmd_c == 2'b10)) ||
              ((state == READ_DATA) && (cmd_c == 2'b11));

    if (state == IDLE) begin
      if (!bus.SS_n) begin
        state_n    = CHK_CMD;
        bit_cnt_n  = '0;
        shift_n    = '0;
        wait_cnt_n = '0;
        tx_cnt_n   = '0;
      end
    end else if (bus.SS_n) begin
      // Deselect: an error only if the frame or the MISO transfer was cut short
      state_n = IDLE;
      if (state inside {CHK_CMD, WRITE, READ_ADD, READ_DATA})
        frame_err_n = (bit_cnt != BCNT_W'(FRAME_W));
      else if (state == TX_SHIFT)
        frame_err_n = (tx_cnt != TCNT_W'(DATA_W));
    end else begin
      case (state)
        CHK_CMD: begin
          shift_n   = frame_c;
          bit_cnt_n = BCNT_W'(1);
          if (!bus.MOSI)     state_n = WRITE;
          else if (addr_pend) state_n = READ_DATA;
          else               state_n = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          // A completed frame parks here with bit_cnt == FRAME_W, ignoring MOSI
          if (bit_cnt != BCNT_W'(FRAME_W)) begin
            shift_n   = frame_c;
            bit_cnt_n = bit_cnt + BCNT_W'(1);
            if (bit_cnt == BCNT_W'(FRAME_W - 1)) begin
              if (legal_c) begin
                rx_data_n  = frame_c;
                rx_valid_n = 1'b1;
                if (state == READ_ADD) addr_pend_n = 1'b1;
                if (state == READ_DATA) begin
                  addr_pend_n = 1'b0;
                  state_n     = TX_WAIT;
                  wait_cnt_n  = '0;
                end
              end else begin
                frame_err_n = 1'b1;
              end
            end
          end
        end
        TX_WAIT: begin
          // wait_cnt == TX_WAIT_MAX marks an expired wait; MISO then stays low
          if (wait_cnt != WCNT_W'(TX_WAIT_MAX)) begin
            if (bus.tx_valid) begin
              state_n  = TX_SHIFT;
              tx_cnt_n = TCNT_W'(1);
              if (LSB_FIRST != 0) begin
                miso_n  = bus.tx_data[0];
                tx_sh_n = bus.tx_data >> 1;
              end else begin
                miso_n  = bus.tx_data[DATA_W-1];
                tx_sh_n = bus.tx_data << 1;
              end
            end else begin
              wait_cnt_n = wait_cnt + WCNT_W'(1);
              if (wait_cnt == WCNT_W'(TX_WAIT_MAX - 1)) frame_err_n = 1'b1;
            end
          end
        end
        TX_SHIFT: begin
          if (tx_cnt != TCNT_W'(DATA_W)) begin
            tx_cnt_n = tx_cnt + TCNT_W'(1);
            if (LSB_FIRST != 0) begin
              miso_n  = tx_sh[0];
              tx_sh_n = tx_sh >> 1;
            end else begin
              miso_n  = tx_sh[DATA_W-1];
              tx_sh_n = tx_sh << 1;
            end
          end
        end
        default: ;
      endcase
    end

    busy_n = (state_n != IDLE);
  end

  assign bus.MISO         = miso;
  assign bus.rx_valid     = rx_valid;
  assign bus.rx_data      = rx_data;
  assign bus.addr_pending = addr_pend;
  assign bus.frame_err    = frame_err;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_spi_slave_frame_ctrl.sv
// Bench for spi_slave_frame_ctrl: two instances (MSB-first/16-edge wait and
// LSB-first/4-edge wait) share stimulus and are compared to a frame-level model.
module tb_spi_slave_frame_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned FW = DW + 2;

  logic clk = 1'b0;
  logic rst;
  logic ss_n, mosi, tx_valid;
  logic [DW-1:0] tx_data;
  bit   cmp_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spi_slave_frame_ctrl_if #(.DATA_W(DW)) bus0 ();
  spi_slave_frame_ctrl_if #(.DATA_W(DW)) bus1 ();

  assign bus0.SS_n = ss_n;  assign bus1.SS_n = ss_n;
  assign bus0.MOSI = mosi;  assign bus1.MOSI = mosi;
  assign bus0.tx_valid = tx_valid;  assign bus1.tx_valid = tx_valid;
  assign bus0.tx_data  = tx_data;   assign bus1.tx_data  = tx_data;

  spi_slave_frame_ctrl #(.DATA_W(DW), .LSB_FIRST(0), .TX_WAIT_MAX(16)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  spi_slave_frame_ctrl #(.DATA_W(DW), .LSB_FIRST(1), .TX_WAIT_MAX(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  // ---------------- behavioural model (one slot per instance) ----------------
  int unsigned m_lsb [2] = '{0, 1};
  int unsigned m_twm [2] = '{16, 4};
  bit          m_act [2];
  int unsigned m_n   [2];   // frame bits received so far
  int unsigned m_kind[2];   // 0 write, 1 read-address, 2 read-data
  int unsigned m_ph  [2];   // 0 receiving, 1 waiting for tx_valid, 2 sending
  int unsigned m_w   [2];   // edges waited
  int unsigned m_t   [2];   // MISO bits sent
  logic [FW-1:0] m_frame[2];
  logic [DW-1:0] m_td   [2];
  logic          e_miso[2], e_rxv[2], e_err[2], e_ap[2], e_busy[2];
  logic [FW-1:0] e_rxd [2];

  function automatic logic tx_bit(input logic [DW-1:0] d, input int unsigned lsb, input int unsigned i);
    return (lsb != 0) ? d[i] : d[DW-1-i];
  endfunction

  task automatic model_step(input int m);
    int unsigned cmd;
    bit legal;
    e_rxv[m] = 1'b0; e_err[m] = 1'b0; e_miso[m] = 1'b0;
    if (rst) begin
      m_act[m] = 0; m_n[m] = 0; m_ph[m] = 0; m_w[m] = 0; m_t[m] = 0;
      m_frame[m] = '0; e_ap[m] = 1'b0; e_rxd[m] = '0;
    end else if (!m_act[m]) begin
      if (!ss_n) begin
        m_act[m] = 1; m_n[m] = 0; m_ph[m] = 0; m_w[m] = 0; m_t[m] = 0; m_frame[m] = '0;
      end
    end else if (ss_n) begin
      e_err[m] = (m_ph[m] == 0 && m_n[m] < FW) || (m_ph[m] == 2 && m_t[m] < DW);
      m_act[m] = 0;
    end else begin
      case (m_ph[m])
        0: if (m_n[m] < FW) begin
          m_frame[m] = FW'(m_frame[m] * 2 + 32'(mosi));
          m_n[m]++;
          if (m_n[m] == 1) m_kind[m] = !mosi ? 0 : (e_ap[m] ? 2 : 1);
          if (m_n[m] == FW) begin
            cmd = 32'(m_frame[m]) >> DW;
            legal = (m_kind[m] == 0 && cmd < 2) || (m_kind[m] == 1 && cmd == 2) ||
                    (m_kind[m] == 2 && cmd == 3);
            if (legal) begin
              e_rxd[m] = m_frame[m]; e_rxv[m] = 1'b1;
              if (m_kind[m] == 1) e_ap[m] = 1'b1;
              if (m_kind[m] == 2) begin e_ap[m] = 1'b0; m_ph[m] = 1; m_w[m] = 0; end
            end else e_err[m] = 1'b1;
          end
        end
        1: if (m_w[m] < m_twm[m]) begin
          if (tx_valid) begin
            m_td[m] = tx_data; m_t[m] = 1; m_ph[m] = 2;
            e_miso[m] = tx_bit(m_td[m], m_lsb[m], 0);
          end else begin
            m_w[m]++;
            if (m_w[m] == m_twm[m]) e_err[m] = 1'b1;
          end
        end
        default: if (m_t[m] < DW) begin
          e_miso[m] = tx_bit(m_td[m], m_lsb[m], m_t[m]);
          m_t[m]++;
        end
      endcase
    end
    e_busy[m] = m_act[m];
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string p, input int m, input logic miso, input logic rxv,
                         input logic [FW-1:0] rxd, input logic ap, input logic err, input logic bsy);
    check({p, "_miso"}, 32'(miso), 32'(e_miso[m]));
    check({p, "_rx_valid"}, 32'(rxv), 32'(e_rxv[m]));
    check({p, "_rx_data"}, 32'(rxd), 32'(e_rxd[m]));
    check({p, "_addr_pending"}, 32'(ap), 32'(e_ap[m]));
    check({p, "_frame_err"}, 32'(err), 32'(e_err[m]));
    check({p, "_busy"}, 32'(bsy), 32'(e_busy[m]));
    if (rxv && err) check({p, "_rxv_err_exclusive"}, 32'(1), 32'(0));
  endtask

  always @(negedge clk) if (cmp_en) begin
    cmp_dut("d0", 0, bus0.MISO, bus0.rx_valid, bus0.rx_data, bus0.addr_pending, bus0.frame_err, bus0.busy);
    cmp_dut("d1", 1, bus1.MISO, bus1.rx_valid, bus1.rx_data, bus1.addr_pending, bus1.frame_err, bus1.busy);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic s, input logic d, input logic v, input logic [DW-1:0] x);
    ss_n = s; mosi = d; tx_valid = v; tx_data = x;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [FW-1:0] f);
    tick(1'b0, 1'b0, 1'b0, '0);
    for (int b = 0; b < FW; b++) tick(1'b0, f[FW-1-b], 1'b0, '0);
  endtask

  task automatic collect(output logic [DW-1:0] c0, output logic [DW-1:0] c1);
    c0 = '0; c1 = '0;
    for (int i = 0; i < DW; i++) begin
      c0 = {c0[DW-2:0], bus0.MISO};
      c1 = {c1[DW-2:0], bus1.MISO};
      if (i < DW - 1) tick(1'b0, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic read_pair(input logic [DW-1:0] d, output logic [DW-1:0] c0, output logic [DW-1:0] c1);
    send_frame(10'h230);
    tick(1'b1, 1'b0, 1'b0, '0);
    send_frame(10'h300);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b1, d);
    collect(c0, c1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] c0, c1;
    logic [FW-1:0] fr;
    int unsigned abort_at, tail;
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_rx_data", 32'(bus0.rx_data), 32'h0);
    check("reset_busy", 32'(bus1.busy), 32'h0);
    rst = 1'b0;
    tick(1'b1, 1'b0, 1'b0, '0);

    // write frame
    send_frame(10'b00_1010_0101);
    check("write_rx_valid", 32'(bus0.rx_valid), 32'h1);
    check("write_rx_data", 32'(bus0.rx_data), 32'h0A5);
    check("write_addr_pending", 32'(bus0.addr_pending), 32'h0);
    tick(1'b1, 1'b0, 1'b0, '0);

    // read address, read data, MISO return
    send_frame(10'h230);
    check("rdaddr_rx_data", 32'(bus0.rx_data), 32'h230);
    check("rdaddr_pending", 32'(bus1.addr_pending), 32'h1);
    tick(1'b1, 1'b0, 1'b0, '0);
    send_frame(10'h300);
    check("rddata_rx_data", 32'(bus0.rx_data), 32'h300);
    check("rddata_pending", 32'(bus0.addr_pending), 32'h0);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b1, 8'hC3);
    collect(c0, c1);
    check("miso_msb_c3", 32'(c0), 32'hC3);
    check("miso_lsb_c3", 32'(c1), 32'hC3);
    tick(1'b0, 1'b0, 1'b0, '0);
    check("miso_after_last", 32'(bus0.MISO), 32'h0);
    tick(1'b1, 1'b0, 1'b0, '0);
    check("tx_done_no_err", 32'(bus0.frame_err), 32'h0);

    read_pair(8'h01, c0, c1);
    check("miso_msb_01", 32'(c0), 32'h01);
    check("miso_lsb_01", 32'(c1), 32'h80);
    tick(1'b1, 1'b0, 1'b0, '0);

    // abort after 5 bits of a write, then a normal frame
    tick(1'b0, 1'b0, 1'b0, '0);
    for (int b = 0; b < 5; b++) tick(1'b0, b[0], 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, '0);
    check("abort_frame_err", 32'(bus0.frame_err), 32'h1);
    check("abort_no_rx_valid", 32'(bus0.rx_valid), 32'h0);
    check("abort_rx_data_kept", 32'(bus0.rx_data), 32'h300);
    send_frame(10'b01_1111_0000);
    check("post_abort_rx_data", 32'(bus0.rx_data), 32'h1F0);
    tick(1'b1, 1'b0, 1'b0, '0);

    // illegal command with no pending address
    send_frame(10'b11_0101_0101);
    check("illegal_frame_err", 32'(bus0.frame_err), 32'h1);
    check("illegal_no_rx_valid", 32'(bus0.rx_valid), 32'h0);
    tick(1'b1, 1'b0, 1'b0, '0);

    // tx timeout: 4 edges on dut1, 16 on dut0
    send_frame(10'h230);
    tick(1'b1, 1'b0, 1'b0, '0);
    send_frame(10'h300);
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b1, 1'b0, 8'hFF);
      if (i == 3) check("timeout4_frame_err", 32'(bus1.frame_err), 32'h1);
      if (i == 3) check("timeout16_not_yet", 32'(bus0.frame_err), 32'h0);
      if (i == 15) check("timeout16_frame_err", 32'(bus0.frame_err), 32'h1);
    end
    tick(1'b0, 1'b0, 1'b1, 8'hFF);
    check("timeout_miso_low", 32'(bus1.MISO), 32'h0);
    tick(1'b1, 1'b0, 1'b0, '0);

    // reset in the middle of TX_SHIFT
    send_frame(10'h230);
    tick(1'b1, 1'b0, 1'b0, '0);
    send_frame(10'h300);
    tick(1'b0, 1'b0, 1'b1, 8'hFF);
    tick(1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0, '0);
    check("rst_miso", 32'(bus0.MISO), 32'h0);
    check("rst_rx_data", 32'(bus0.rx_data), 32'h0);
    check("rst_busy", 32'(bus0.busy), 32'h0);
    check("rst_frame_err", 32'(bus0.frame_err), 32'h0);
    rst = 1'b0;
    tick(1'b1, 1'b0, 1'b0, '0);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      fr = FW'($urandom);
      abort_at = ($urandom_range(0, 6) == 0) ? $urandom_range(0, FW - 1) : FW;
      tick(1'b0, 1'($urandom), 1'($urandom), DW'($urandom));
      for (int b = 0; b < int'(abort_at); b++)
        tick(1'b0, fr[FW-1-b], ($urandom_range(0, 3) == 0), DW'($urandom));
      if (abort_at == FW) begin
        tail = $urandom_range(0, 16);
        for (int j = 0; j < int'(tail); j++)
          tick(1'b0, 1'($urandom), ($urandom_range(0, 3) == 0), DW'($urandom));
      end
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        tick(1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom));
        rst = 1'b0;
      end
      tick(1'b1, 1'($urandom), ($urandom_range(0, 3) == 0), DW'($urandom));
      if ($urandom_range(0, 1) == 0) tick(1'b1, 1'b0, 1'b0, '0);
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
